// File: rtl/cache_req_rr_arbiter.sv
// Four-requester round-robin merge for cache requests.
// Each requester owns a one-entry slot; one registered output slot.
module cache_req_rr_arbiter #(
    parameter int DATA_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_valid0,
    input  logic                  i_valid1,
    input  logic                  i_valid2,
    input  logic                  i_valid3,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    input  logic [DATA_WIDTH-1:0] i_data2,
    input  logic [DATA_WIDTH-1:0] i_data3,
    output logic                  o_ready0,
    output logic                  o_ready1,
    output logic                  o_ready2,
    output logic                  o_ready3,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_src,
    input  logic                  i_ready
);

    logic [3:0]            full;
    logic [DATA_WIDTH-1:0] slot [4];
    logic [DATA_WIDTH-1:0] din  [4];
    logic [3:0]            valid_in;
    logic [3:0]            ready;
    logic [3:0]            acc;
    logic [3:0]            gfire_vec;
    logic [1:0]            ptr;
    logic [1:0]            win;
    logic                  out_free;
    logic                  gfire;

    assign valid_in = {i_valid3, i_valid2, i_valid1, i_valid0};
    assign din[0]   = i_data0;
    assign din[1]   = i_data1;
    assign din[2]   = i_data2;
    assign din[3]   = i_data3;

    // Scan from the farthest offset down so the nearest full slot to ptr wins.
    always_comb begin
        win = '0;
        for (int i = 3; i >= 0; i--) begin
            if (full[ptr + 2'(i)]) win = ptr + 2'(i);
        end
    end

    assign out_free  = ~o_valid | i_ready;
    assign gfire     = out_free & (|full);
    assign gfire_vec = gfire ? (4'b0001 << win) : 4'b0000;
    assign ready     = ~full | gfire_vec;
    assign acc       = valid_in & ready;

    assign o_ready0 = ready[0];
    assign o_ready1 = ready[1];
    assign o_ready2 = ready[2];
    assign o_ready3 = ready[3];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            full    <= '0;
            ptr     <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_src   <= '0;
            for (int i = 0; i < 4; i++) slot[i] <= '0;
        end else begin
            // A refill on the granted slot wins over its clear.
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    full[i] <= 1'b1;
                    slot[i] <= din[i];
                end else if (gfire_vec[i]) begin
                    full[i] <= 1'b0;
                end
            end
            if (gfire) begin
                o_valid <= 1'b1;
                o_data  <= slot[win];
                o_src   <= win;
                ptr     <= win + 2'd1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cache_req_rr_arbiter.sv
// Scenario bench for cache_req_rr_arbiter.
// Accepted payloads are queued in expected order and checked on consume.
module tb_cache_req_rr_arbiter;

    localparam int W = 5;

    logic          clk     = 1'b0;
    logic          rstn    = 1'b0;
    logic          i_ready = 1'b0;
    logic [3:0]    vld     = 4'b0000;
    logic [W-1:0]  dat [4];
    logic [3:0]    rdy;
    logic          o_valid;
    logic [W-1:0]  o_data;
    logic [1:0]    o_src;
    logic [W+1:0]  exp_q [$];
    logic [W+1:0]  mon_exp;
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    cache_req_rr_arbiter #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_valid0 (vld[0]),
        .i_valid1 (vld[1]),
        .i_valid2 (vld[2]),
        .i_valid3 (vld[3]),
        .i_data0  (dat[0]),
        .i_data1  (dat[1]),
        .i_data2  (dat[2]),
        .i_data3  (dat[3]),
        .o_ready0 (rdy[0]),
        .o_ready1 (rdy[1]),
        .o_ready2 (rdy[2]),
        .o_ready3 (rdy[3]),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_src    (o_src),
        .i_ready  (i_ready)
    );

    // Every payload consumed downstream must match the queue head.
    always @(negedge clk) begin
        if (rstn && o_valid && i_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_extra got src=%0d data=%h required none",
                         o_src, o_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({o_src, o_data} !== mon_exp) begin
                    failures++;
                    $display("FAIL scoreboard got src=%0d data=%h required src=%0d data=%h",
                             o_src, o_data, mon_exp[W+1:W], mon_exp[W-1:0]);
                end
            end
        end
    end

    task automatic step(output logic [3:0] accd);
        @(negedge clk);
        accd = vld & rdy;
        for (int i = 0; i < 4; i++) begin
            if (accd[i]) exp_q.push_back({2'(i), dat[i]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        logic [3:0] a;
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < 40) begin
            step(a);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_drain left=%0d o_valid=%b required 0 and 0",
                     name, exp_q.size(), o_valid);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        vld  = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] a;
        rstn    = 1'b0;
        i_ready = 1'b0;
        vld     = 4'b1111;
        for (int i = 0; i < 4; i++) dat[i] = 5'h1F;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_data !== '0 || o_src !== 2'd0) begin
            failures++;
            $display("FAIL reset_out got v=%b d=%h s=%0d required 0 00 0",
                     o_valid, o_data, o_src);
        end
        checks++;
        if (rdy !== 4'b1111) begin
            failures++;
            $display("FAIL reset_ready got %b required 1111", rdy);
        end
        vld  = 4'b0000;
        rstn = 1'b1;
        step(a);
        checks++;
        if (rdy !== 4'b1111 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got rdy=%b v=%b required 1111 0", rdy, o_valid);
        end
    endtask

    task automatic test_single();
        logic [3:0] a;
        i_ready = 1'b1;
        vld[2]  = 1'b1;
        dat[2]  = 5'h13;
        step(a);
        vld = 4'b0000;
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early got v=%b required 0", o_valid);
        end
        step(a);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 5'h13 || o_src !== 2'd2) begin
            failures++;
            $display("FAIL single_out got v=%b d=%h s=%0d required 1 13 2",
                     o_valid, o_data, o_src);
        end
        step(a);
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_clear got v=%b required 0", o_valid);
        end
        drain("single");
    endtask

    task automatic test_all_four();
        logic [3:0] a;
        do_reset();
        i_ready = 1'b1;
        vld     = 4'b1111;
        for (int i = 0; i < 4; i++) dat[i] = W'(i + 1);
        step(a);
        vld = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            step(a);
            checks++;
            if (o_valid !== 1'b1 || o_src !== 2'(k) || o_data !== W'(k + 1)) begin
                failures++;
                $display("FAIL all_four_%0d got v=%b s=%0d d=%h required 1 %0d %h",
                         k, o_valid, o_src, o_data, k, k + 1);
            end
        end
        drain("all_four");
    endtask

    task automatic test_alternate();
        logic [3:0] a;
        int prev;
        prev   = -1;
        vld    = 4'b1010;
        dat[1] = 5'h00;
        dat[3] = 5'h10;
        for (int c = 0; c < 10; c++) begin
            step(a);
            if (a[1]) dat[1] = dat[1] + 1'b1;
            if (a[3]) dat[3] = dat[3] + 1'b1;
            if (o_valid) begin
                checks++;
                if (int'(o_src) == prev) begin
                    failures++;
                    $display("FAIL alternate_repeat got s=%0d twice required alternation",
                             o_src);
                end
                prev = int'(o_src);
            end
        end
        vld = 4'b0000;
        drain("alternate");
    endtask

    task automatic test_backpressure();
        logic [3:0] a;
        do_reset();
        i_ready = 1'b0;
        vld     = 4'b1111;
        for (int i = 0; i < 4; i++) dat[i] = W'(5'h11 + i);
        step(a);
        vld    = 4'b0001;
        dat[0] = 5'h15;
        step(a);
        checks++;
        if (a !== 4'b0001) begin
            failures++;
            $display("FAIL bp_refill got acc=%b required 0001", a);
        end
        vld = 4'b1111;
        for (int i = 0; i < 4; i++) dat[i] = 5'h1E;
        for (int c = 0; c < 5; c++) begin
            step(a);
            checks++;
            if (o_valid !== 1'b1 || o_data !== 5'h11 || o_src !== 2'd0 || rdy !== 4'b0000) begin
                failures++;
                $display("FAIL bp_hold_%0d got v=%b d=%h s=%0d rdy=%b required 1 11 0 0000",
                         c, o_valid, o_data, o_src, rdy);
            end
        end
        vld     = 4'b0000;
        i_ready = 1'b1;
        drain("backpressure");
    endtask

    task automatic test_refill();
        logic [3:0] a;
        logic [W-1:0] seq [3];
        seq[0] = 5'h0A;
        seq[1] = 5'h0B;
        seq[2] = 5'h0C;
        do_reset();
        i_ready = 1'b1;
        vld[0]  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dat[0] = seq[k];
            step(a);
            checks++;
            if (a[0] !== 1'b1) begin
                failures++;
                $display("FAIL refill_ready_%0d got acc0=%b required 1", k, a[0]);
            end
        end
        vld = 4'b0000;
        drain("refill");
    endtask

    task automatic test_reset_mid();
        logic [3:0] a;
        do_reset();
        i_ready = 1'b0;
        vld     = 4'b1111;
        for (int i = 0; i < 4; i++) dat[i] = W'(5'h01 + i);
        step(a);
        vld = 4'b0000;
        step(a);
        checks++;
        if (o_valid !== 1'b1 || rdy !== 4'b0001) begin
            failures++;
            $display("FAIL mid_setup got v=%b rdy=%b required 1 0001", o_valid, rdy);
        end
        rstn   = 1'b0;
        vld    = 4'b0001;
        dat[0] = 5'h1F;
        @(posedge clk);
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_data !== '0 || rdy !== 4'b1111) begin
            failures++;
            $display("FAIL mid_reset got v=%b d=%h rdy=%b required 0 00 1111",
                     o_valid, o_data, rdy);
        end
        exp_q.delete();
        rstn    = 1'b1;
        i_ready = 1'b1;
        vld     = 4'b0101;
        dat[0]  = 5'h07;
        dat[2]  = 5'h09;
        step(a);
        vld = 4'b0000;
        step(a);
        checks++;
        if (o_valid !== 1'b1 || o_src !== 2'd0 || o_data !== 5'h07) begin
            failures++;
            $display("FAIL mid_first got v=%b s=%0d d=%h required 1 0 07",
                     o_valid, o_src, o_data);
        end
        drain("reset_mid");
    endtask

    initial begin
        for (int i = 0; i < 4; i++) dat[i] = '0;
        test_reset();
        test_single();
        test_all_four();
        test_alternate();
        test_backpressure();
        test_refill();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_req_rr_arbiter.md
CACHE_REQ_RR_ARBITER -- requirements
Module: cache_req_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5, the payload width per requester.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn, input, 1 bit, reset, synchronous and active-low.
REQ-004 SHALL have ports i_valid0..i_valid3, input, 1 bit each, requester n offers i_data_n.
REQ-005 SHALL have ports i_data0..i_data3, input, DATA_WIDTH each, requester payloads.
REQ-006 SHALL have ports o_ready0..o_ready3, output, 1 bit each, requester n payload is accepted at this edge.
REQ-007 SHALL have port o_valid, output, 1 bit, the output register holds a payload.
REQ-008 SHALL have port o_data, output, DATA_WIDTH, the merged payload.
REQ-009 SHALL have port o_src, output, 2 bits, the index of the requester that supplied o_data.
REQ-010 SHALL have port i_ready, input, 1 bit, the downstream consumes o_data at this edge when o_valid is high.

Function
REQ-011 SHALL hold one slot per requester: full_n flag plus a DATA_WIDTH data register.
REQ-012 SHALL handshake on input n (acc_n) when i_valid_n and o_ready_n are high at a rising edge; acc_n SHALL set full_n and capture i_data_n.
REQ-013 SHALL drive o_ready_n = ~full_n | gfire_n, where gfire_n means slot n is granted and moved to the output at this edge.
REQ-014 SHALL hold one output slot. out_free = ~o_valid | i_ready.
REQ-015 SHALL compute grant combinationally among full slots: round-robin starting at pointer ptr[1:0]; first full slot at ptr, ptr+1, ... (mod 4) wins; no grant when all slots are empty.
REQ-016 SHALL fire a grant (gfire) only when out_free and some slot is full; at that edge it SHALL load o_data/o_src from the winner, set o_valid, clear the winner's full_n unless acc_n occurs at the same edge, and set ptr = winner+1 mod 4.
REQ-017 SHALL clear o_valid at an edge with o_valid & i_ready and no gfire; o_data/o_src SHALL then hold their last values.
REQ-018 SHALL hold ptr unchanged at edges without gfire.
REQ-019 SHALL have a latency of 2 edges: acc at edge E0 -> o_valid high after E1 if the output is free and the slot wins at E1.
REQ-020 SHALL reach a throughput of one payload per cycle when i_ready is held high and at least one slot is full every cycle.
REQ-021 SHALL handle simultaneous acc_n and gfire_n on the same slot: the slot SHALL remain full with the new data, and the old data SHALL go to the output.
REQ-022 SHALL apply backpressure: with o_valid=1 and i_ready=0, no gfire occurs, and the slot and ptr state SHALL be frozen except for acc on empty slots.
REQ-023 SHALL guarantee no starvation: a full slot SHALL be granted within 4 gfire events.
REQ-024 SHALL keep a payload accepted once from being dropped or duplicated; order within one requester SHALL be preserved.

Reset
REQ-025 SHALL, when rstn=0 at a rising edge: full0..3=0, o_valid=0, o_data=0, o_src=0, ptr=0, slot data=0.
REQ-026 SHALL drive o_ready0..3 = 1 at the first edge after reset is released.
REQ-027 SHALL have reset asserted mid-operation discard all held payloads, and SHALL ignore in-flight handshakes at that edge.

Verification
REQ-028 Single request: i_valid2=1, i_data2=5'h13 for one edge, i_ready=1 -> o_valid=1, o_data=5'h13, o_src=2 exactly 2 edges later, then o_valid=0.
REQ-029 All four valid together, data 0x01/0x02/0x03/0x04, i_ready=1 -> outputs in source order 0,1,2,3, one per cycle, ptr=0 afterward.
REQ-030 Continuous requests on inputs 1 and 3 only -> o_src alternates 1,3,1,3; neither source is granted twice in a row.
REQ-031 Backpressure: i_ready=0 for 5 cycles with all slots full -> o_data stable, o_ready0..3=0, ptr unchanged; release -> 4 payloads drained, no loss or duplication.
REQ-032 Same-slot refill: input 0 streams 0x0A,0x0B,0x0C back-to-back with i_ready=1 -> o_ready0 stays 1, outputs 0x0A,0x0B,0x0C in order.
REQ-033 Reset mid-stream with o_valid=1 and 3 slots full -> one edge later o_valid=0, o_data=0, o_ready0..3=1, and the next grant starts from source 0.
